snoop_bus_controller: RTL and testbench

SNOOP_BUS_CONTROLLER -- requirements
Module: snoop_bus_controller

---
 rtl/snoop_bus_controller.sv | 152 +++++++++++++++
 tb/tb_snoop_bus_controller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_controller.sv
// Snooping bus controller: round-robin arbitration among four caches, a
// one-cycle snoop, optional write-back, memory fill and a wait timeout.
module snoop_bus_controller #(
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   RdMs,
  input  logic [3:0]   WrMs,
  input  logic [3:0]   WrBk,
  input  logic [127:0] addressIn,
  input  logic [127:0] dataIn,
  input  logic [3:0]   sharedIn,
  output logic [1:0]   currProc_ID,
  output logic [31:0]  busAddress,
  output logic         busRdWr,
  output logic         busValid,
  output logic         shared,
  output logic         readyToRead,
  output logic [31:0]  busData,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_ack,
  output logic         busError
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GRANT = 3'd1;
  localparam logic [2:0] SNOOP = 3'd2;
  localparam logic [2:0] WB    = 3'd3;
  localparam logic [2:0] MEMRD = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [2:0]    r_state, w_next;
  logic [1:0]    r_ptr, r_curr, r_wb_idx;
  logic [CW-1:0] r_wait;
  logic [31:0]   r_addr, r_data, r_mem_addr, r_mem_wdata;
  logic          r_rdwr, r_valid, r_shared, r_ready, r_mem_req, r_mem_we, r_err;

  logic [3:0] w_req;
  logic [1:0] w_gnt, w_wb_idx, w_wb_sel;
  logic       w_gnt_vld, w_wb_vld, w_shared, w_timeout, w_wait_end, w_stay_acc;

  assign w_req = RdMs | WrMs;

  // Lowest offset from the pointer wins, so scan offsets from high to low.
  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (w_req[r_ptr + 2'(k)]) begin
        w_gnt     = r_ptr + 2'(k);
        w_gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_wb_idx = '0;
    w_wb_vld = 1'b0;
    for (int j = 3; j >= 0; j--) begin
      if (2'(j) != r_curr && WrBk[j]) begin
        w_wb_idx = 2'(j);
        w_wb_vld = 1'b1;
      end
    end
  end

  assign w_shared   = |(sharedIn & ~(4'b0001 << r_curr));
  assign w_wb_sel   = (r_state == SNOOP) ? w_wb_idx : r_wb_idx;
  assign w_wait_end = (r_wait == CW'(TIMEOUT - 1));

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      IDLE:  if (w_gnt_vld) w_next = GRANT;
      GRANT: w_next = SNOOP;
      SNOOP: w_next = w_wb_vld ? WB : (r_rdwr ? MEMRD : DONE);
      WB: begin
        if (mem_ack)         w_next = r_rdwr ? MEMRD : DONE;
        else if (w_wait_end) begin w_next = IDLE; w_timeout = 1'b1; end
      end
      MEMRD: begin
        if (mem_ack)         w_next = DONE;
        else if (w_wait_end) begin w_next = IDLE; w_timeout = 1'b1; end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_stay_acc = (r_state == WB || r_state == MEMRD) && (w_next == r_state);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_curr      <= '0;
      r_wb_idx    <= '0;
      r_wait      <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdwr      <= 1'b0;
      r_valid     <= 1'b0;
      r_shared    <= 1'b0;
      r_ready     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_valid   <= (w_next != IDLE);
      r_ready   <= (w_next == DONE);
      r_err     <= w_timeout;
      r_wait    <= w_stay_acc ? r_wait + 1'b1 : '0;
      r_mem_req <= (w_next == WB) || (w_next == MEMRD);
      r_mem_we  <= (w_next == WB);
      r_mem_addr  <= ((w_next == WB) || (w_next == MEMRD)) ? r_addr : '0;
      r_mem_wdata <= (w_next == WB) ? dataIn[32*w_wb_sel +: 32] : '0;
      if (r_state == IDLE && w_gnt_vld) begin
        r_curr <= w_gnt;
        r_addr <= addressIn[32*w_gnt +: 32];
        r_rdwr <= RdMs[w_gnt];
        r_ptr  <= w_gnt + 2'd1;
      end
      if (r_state == SNOOP) begin
        r_shared <= w_shared;
        r_wb_idx <= w_wb_idx;
      end
      if (r_state == MEMRD && mem_ack) r_data <= mem_rdata;
    end
  end

  assign currProc_ID = r_curr;
  assign busAddress  = r_addr;
  assign busRdWr     = r_rdwr;
  assign busValid    = r_valid;
  assign shared      = r_shared;
  assign readyToRead = r_ready;
  assign busData     = r_data;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign busError    = r_err;
endmodule

// File: tb/tb_snoop_bus_controller.sv
// Directed and randomized transactions against a transaction-level model of
// arbitration order, snoop results, memory traffic and completion timing.
module tb_snoop_bus_controller;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   RdMs, WrMs, WrBk, sharedIn;
  logic [127:0] addressIn, dataIn;
  logic [1:0]   currProc_ID;
  logic [31:0]  busAddress, busData, mem_addr, mem_wdata, mem_rdata;
  logic         busRdWr, busValid, shared, readyToRead, mem_req, mem_we, mem_ack, busError;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  snoop_bus_controller #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .RdMs(RdMs), .WrMs(WrMs), .WrBk(WrBk),
    .addressIn(addressIn), .dataIn(dataIn), .sharedIn(sharedIn),
    .currProc_ID(currProc_ID), .busAddress(busAddress), .busRdWr(busRdWr),
    .busValid(busValid), .shared(shared), .readyToRead(readyToRead),
    .busData(busData), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busError(busError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rnd_bus();
    addressIn = {$urandom, $urandom, $urandom, $urandom};
    dataIn    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One transaction from an IDLE cycle; wbd/rdd = wait cycles before mem_ack
  // (>= TO means never acknowledged); spur drives mem_ack while no access is open.
  task automatic txn(input logic [3:0] rd, input logic [3:0] wr, input logic [3:0] wrbk,
                     input logic [3:0] shin, input int wbd, input int rdd,
                     input bit spur, input logic [31:0] rdata);
    int g, wbj, exp_k, kend, wb_cnt, rd_cnt, exp_wb_cnt, exp_rd_cnt;
    bit is_rd, exp_sh, exp_err, got_err;
    logic [31:0] wb_data, wb_addr, rd_addr;
    logic [3:0]  req;
    req = rd | wr;
    g = -1;
    for (int k = 3; k >= 0; k--) if (req[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    m_ptr = (g + 1) % 4;
    is_rd  = rd[g];
    wbj    = -1;
    exp_sh = 1'b0;
    for (int j = 3; j >= 0; j--) begin
      if (j != g && wrbk[j]) wbj = j;
      if (j != g) exp_sh |= shin[j];
    end
    exp_k = 3; exp_err = 1'b0; exp_wb_cnt = 0; exp_rd_cnt = 0;
    if (wbj >= 0) begin
      if (wbd >= TO) begin exp_err = 1'b1; exp_k += TO; exp_wb_cnt = TO; end
      else begin exp_k += wbd + 1; exp_wb_cnt = wbd + 1; end
    end
    if (is_rd && !exp_err) begin
      if (rdd >= TO) begin exp_err = 1'b1; exp_k += TO; exp_rd_cnt = TO; end
      else begin exp_k += rdd + 1; exp_rd_cnt = rdd + 1; end
    end

    RdMs = rd; WrMs = wr; WrBk = wrbk; sharedIn = shin; mem_rdata = rdata; mem_ack = 1'b0;
    kend = -1; got_err = 1'b0; wb_cnt = 0; rd_cnt = 0;
    wb_data = '0; wb_addr = '0; rd_addr = '0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("grant_owner", 32'(currProc_ID), g);
        chk("grant_addr", busAddress, addressIn[32*g +: 32]);
        chk("grant_rdwr_valid", {busRdWr, busValid}, {is_rd, 1'b1});
      end
      if (mem_req && mem_we) begin
        wb_cnt++; wb_data = mem_wdata; wb_addr = mem_addr;
        mem_ack = (wb_cnt == wbd + 1);
      end else if (mem_req) begin
        rd_cnt++; rd_addr = mem_addr;
        mem_ack = (rd_cnt == rdd + 1);
      end else mem_ack = spur;
      if (readyToRead || busError) begin
        kend = k; got_err = busError;
        break;
      end
    end
    mem_ack = 1'b0; RdMs = '0; WrMs = '0; WrBk = '0;
    chk("end_cycle", kend, exp_k);
    chk("error_flag", 32'(got_err), 32'(exp_err));
    chk("owner_held", 32'(currProc_ID), g);
    chk("shared", 32'(shared), 32'(exp_sh));
    chk("wb_cycles", wb_cnt, exp_wb_cnt);
    chk("rd_cycles", rd_cnt, exp_rd_cnt);
    if (wbj >= 0) begin
      chk("wb_data", wb_data, dataIn[32*wbj +: 32]);
      chk("wb_addr", wb_addr, addressIn[32*g +: 32]);
    end
    if (exp_rd_cnt > 0) chk("rd_addr", rd_addr, addressIn[32*g +: 32]);
    if (is_rd && !exp_err) chk("busData", busData, rdata);
    @(negedge clk);
    chk("post_idle", {readyToRead, busError, busValid, mem_req}, 4'b0000);
  endtask

  initial begin
    reset = 1'b0; RdMs = '0; WrMs = '0; WrBk = '0; sharedIn = '0;
    addressIn = '0; dataIn = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {currProc_ID, busRdWr, busValid, shared, readyToRead, mem_req, mem_we, busError}, '0);
    chk("rst_busAddress", busAddress, '0);
    chk("rst_busData", busData, '0);
    chk("rst_mem_bus", mem_addr | mem_wdata, '0);
    reset = 1'b1;
    @(negedge clk);

    // Single read miss, ack in the first MEMRD cycle
    rnd_bus();
    txn(4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1'b0, 32'hDEADBEEF);

    // Reset while a write-back is outstanding, with a coincident mem_ack
    rnd_bus();
    RdMs = 4'b0100; WrBk = 4'b0010; mem_rdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    chk("rstwb_in_wb", {mem_req, mem_we}, 2'b11);
    reset = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    chk("rstwb_flags", {currProc_ID, busRdWr, busValid, shared, readyToRead, mem_req, mem_we, busError}, '0);
    chk("rstwb_busAddress", busAddress, '0);
    chk("rstwb_busData", busData, '0);
    chk("rstwb_mem_bus", mem_addr | mem_wdata, '0);
    reset = 1'b1; mem_ack = 1'b0; RdMs = '0; WrBk = '0; m_ptr = 0;
    @(negedge clk);

    // All four requesting: rotation 0,1,2,3,0 from a cleared pointer
    for (int n = 0; n < 5; n++) begin
      rnd_bus();
      txn(4'b1111, 4'b0000, 4'b0000, 4'($urandom), 0, n % 3, 1'b0, $urandom);
      chk("rr_order", 32'(currProc_ID), n % 4);
    end

    // Write-back from cache 1 then fill for cache 2
    rnd_bus();
    dataIn[63:32] = 32'h55;
    txn(4'b0100, 4'b0000, 4'b0010, 4'b0010, 1, 2, 1'b1, $urandom);
    // Write miss, no write-back: no memory traffic
    rnd_bus();
    txn(4'b0000, 4'b1000, 4'b1000, 4'b0111, 0, 0, 1'b0, $urandom);
    // Read wins over write for the same cache
    rnd_bus();
    txn(4'b0010, 4'b0010, 4'b0000, 4'b1111, 0, 0, 1'b0, $urandom);
    // Read ack withheld; ack on the last permitted cycle; write-back timeout
    rnd_bus();
    txn(4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 99, 1'b0, $urandom);
    rnd_bus();
    txn(4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, TO - 1, 1'b0, $urandom);
    rnd_bus();
    txn(4'b0000, 4'b0100, 4'b0001, 4'b0001, 99, 0, 1'b0, $urandom);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] rd, wr;
      int wbd, rdd;
      rd = 4'($urandom); wr = 4'($urandom);
      if ((rd | wr) == 4'b0000) rd = 4'b0001;
      wbd = ($urandom_range(0, 9) == 0) ? TO + 3 : int'($urandom_range(0, 3));
      rdd = ($urandom_range(0, 9) == 0) ? TO + 3 : int'($urandom_range(0, 3));
      rnd_bus();
      txn(rd, wr, 4'($urandom), 4'($urandom), wbd, rdd, 1'($urandom), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
